// File: rtl/mem_bus_arb_pkg.sv
// Shared types and default widths for the two-master Avalon-MM memory bus arbiter.
package mem_bus_arb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_GRANT0 = 2'd1,
        ARB_GRANT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_rr_pick.sv
// Round-robin next-grant selection: purely combinational, driven only by
// registered state plus the current request/completion view.
module arb_rr_pick
    import mem_bus_arb_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    input  arb_state_t state,
    input  logic       done,
    output arb_state_t next_state
);

    // Next-state selection; a tie from idle goes to the master that was not granted last.
    always_comb begin
        next_state = ARB_IDLE;
        case (state)
            ARB_IDLE: begin
                if (req0 && req1) begin
                    if (last) begin
                        next_state = ARB_GRANT0;
                    end else begin
                        next_state = ARB_GRANT1;
                    end
                end else if (req0) begin
                    next_state = ARB_GRANT0;
                end else if (req1) begin
                    next_state = ARB_GRANT1;
                end else begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_GRANT0: begin
                // A dropped request abandons the grant without completing.
                if (!req0) begin
                    next_state = ARB_IDLE;
                end else if (done) begin
                    if (req1) begin
                        next_state = ARB_GRANT1;
                    end else begin
                        next_state = ARB_IDLE;
                    end
                end else begin
                    next_state = ARB_GRANT0;
                end
            end
            ARB_GRANT1: begin
                if (!req1) begin
                    next_state = ARB_IDLE;
                end else if (done) begin
                    if (req0) begin
                        next_state = ARB_GRANT0;
                    end else begin
                        next_state = ARB_IDLE;
                    end
                end else begin
                    next_state = ARB_GRANT1;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master Avalon-MM arbiter: registered round-robin grant, one transfer per grant,
// combinational request/response muxing selected by the registered state.
module mem_bus_arbiter
    import mem_bus_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state_r;
    arb_state_t next_state_s;
    logic       last_r;
    logic       req0_s;
    logic       req1_s;
    logic       done_s;

    assign req0_s = m0_read | m0_write;
    assign req1_s = m1_read | m1_write;

    // Completion flag: the granted master is still requesting and the slave accepts.
    always_comb begin
        done_s = 1'b0;
        case (state_r)
            ARB_GRANT0: done_s = req0_s & ~s_waitrequest;
            ARB_GRANT1: done_s = req1_s & ~s_waitrequest;
            default:    done_s = 1'b0;
        endcase
    end

    arb_rr_pick u_pick (
        .req0       (req0_s),
        .req1       (req1_s),
        .last       (last_r),
        .state      (state_r),
        .done       (done_s),
        .next_state (next_state_s)
    );

    // Grant state and round-robin pointer; last resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ARB_IDLE;
            last_r  <= 1'b1;
        end else begin
            state_r <= next_state_s;
            if (next_state_s == ARB_GRANT0) begin
                last_r <= 1'b0;
            end else if (next_state_s == ARB_GRANT1) begin
                last_r <= 1'b1;
            end else begin
                last_r <= last_r;
            end
        end
    end

    // Port muxes: forward the granted master to the slave and route the response back.
    always_comb begin
        s_address      = {ADDR_W{1'b0}};
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = {DATA_W{1'b0}};
        s_byteenable   = {BE_W{1'b0}};
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        m0_readdata    = {DATA_W{1'b0}};
        m1_readdata    = {DATA_W{1'b0}};
        busy           = 1'b0;
        case (state_r)
            ARB_GRANT0: begin
                s_address      = m0_address;
                s_read         = m0_read;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                busy           = 1'b1;
            end
            ARB_GRANT1: begin
                s_address      = m1_address;
                s_read         = m1_read;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                busy           = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a grant model.
module tb_mem_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] m0_address = '0, m1_address = '0;
    logic          m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
    logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
    logic          m0_waitrequest, m1_waitrequest;
    logic [DW-1:0] m0_readdata, m1_readdata;
    logic [AW-1:0] s_address;
    logic          s_read, s_write;
    logic [DW-1:0] s_writedata;
    logic [BW-1:0] s_byteenable;
    logic          s_waitrequest = 1'b0;
    logic [DW-1:0] s_readdata = '0;
    logic          busy;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which master (-1 none) holds the bus, and who was granted last.
    int mg = -1;
    bit ml = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mg = -1;
            ml = 1'b1;
        end else begin
            bit r0, r1, rg, ro;
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (mg < 0) begin
                if (r0 && r1)  mg = ml ? 0 : 1;
                else if (r0)   mg = 0;
                else if (r1)   mg = 1;
                if (mg >= 0)   ml = (mg == 1);
            end else begin
                rg = (mg == 0) ? r0 : r1;
                ro = (mg == 0) ? r1 : r0;
                if (!rg) begin
                    mg = -1;
                end else if (!s_waitrequest) begin
                    if (ro) begin
                        mg = 1 - mg;
                        ml = (mg == 1);
                    end else begin
                        mg = -1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic [AW-1:0] ea;
        logic          er, ew;
        logic [DW-1:0] ed;
        logic [BW-1:0] eb;
        ea = '0; er = 1'b0; ew = 1'b0; ed = '0; eb = '0;
        if (mg == 0) begin
            ea = m0_address; er = m0_read; ew = m0_write; ed = m0_writedata; eb = m0_byteenable;
        end else if (mg == 1) begin
            ea = m1_address; er = m1_read; ew = m1_write; ed = m1_writedata; eb = m1_byteenable;
        end
        chk("s_address", 64'(s_address), 64'(ea));
        chk("s_read", 64'(s_read), 64'(er));
        chk("s_write", 64'(s_write), 64'(ew));
        chk("s_writedata", 64'(s_writedata), 64'(ed));
        chk("s_byteenable", 64'(s_byteenable), 64'(eb));
        chk("busy", 64'(busy), 64'(mg >= 0));
        chk("m0_waitrequest", 64'(m0_waitrequest), 64'(!(mg == 0 && !s_waitrequest)));
        chk("m1_waitrequest", 64'(m1_waitrequest), 64'(!(mg == 1 && !s_waitrequest)));
        chk("m0_readdata", 64'(m0_readdata), 64'((mg == 0) ? s_readdata : '0));
        chk("m1_readdata", 64'(m1_readdata), 64'((mg == 1) ? s_readdata : '0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rv;
        step(); step();
        chk("rst_busy", 64'(busy), 64'(1'b0));
        chk("rst_m0_wait", 64'(m0_waitrequest), 64'(1'b1));
        reset = 1'b1;
        step();

        // Reset mid-transfer: m0 granted and stalled, reset dropped mid-cycle.
        m0_address = 32'h0000_0040; m0_read = 1'b1; s_waitrequest = 1'b1;
        step(); step();
        chk("pre_rst_s_read", 64'(s_read), 64'(1'b1));
        #2 reset = 1'b0;
        #1;
        chk("midrst_s_read", 64'(s_read), 64'(1'b0));
        chk("midrst_busy", 64'(busy), 64'(1'b0));
        chk("midrst_m0_wait", 64'(m0_waitrequest), 64'(1'b1));
        chk("midrst_m1_wait", 64'(m1_waitrequest), 64'(1'b1));
        idle_all(); s_waitrequest = 1'b0;
        step();
        reset = 1'b1;
        step();

        // Contention: both request together, zero-wait slave, 4 transfers each.
        m0_address = 32'h0000_0100; m0_read = 1'b1;
        m1_address = 32'h0000_0200; m1_write = 1'b1; m1_writedata = 32'h1234_5678;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("cont_order", 64'(s_address), (i % 2 == 0) ? 64'h100 : 64'h200);
            chk("cont_busy", 64'(busy), 64'(1'b1));
            if (i % 2 == 0) chk("cont_m1_wait", 64'(m1_waitrequest), 64'(1'b1));
        end
        idle_all();
        step();

        // Single read from the boot vector.
        m0_address = 32'hBFC0_0000; m0_read = 1'b1; s_readdata = 32'h0000_00FF;
        step();
        chk("rd_s_read", 64'(s_read), 64'(1'b1));
        chk("rd_s_addr", 64'(s_address), 64'hBFC0_0000);
        chk("rd_m0_data", 64'(m0_readdata), 64'hFF);
        chk("rd_m0_wait", 64'(m0_waitrequest), 64'(1'b0));
        step();
        chk("rd_idle_busy", 64'(busy), 64'(1'b0));
        chk("rd_idle_s_read", 64'(s_read), 64'(1'b0));
        idle_all();
        step();

        // Slave stall on an m1 write while m0 waits.
        m1_address = 32'h0000_1000; m1_write = 1'b1; m1_writedata = 32'hDEAD_BEEF;
        m1_byteenable = 4'b0011; s_waitrequest = 1'b1;
        step();
        m0_address = 32'h0000_0300; m0_read = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) s_waitrequest = 1'b0;
            #1;
            chk("stall_addr", 64'(s_address), 64'h1000);
            chk("stall_wdata", 64'(s_writedata), 64'hDEAD_BEEF);
            chk("stall_be", 64'(s_byteenable), 64'h3);
            chk("stall_m0_wait", 64'(m0_waitrequest), 64'(1'b1));
            chk("stall_m1_wait", 64'(m1_waitrequest), 64'(i != 3));
            step();
        end
        m1_write = 1'b0;
        #1;
        chk("stall_handover", 64'(s_address), 64'h300);
        chk("stall_m0_read", 64'(s_read), 64'(1'b1));
        step();
        idle_all();
        step();

        // Request dropped while stalled, then a tie must go to m1.
        m0_address = 32'h0000_0400; m0_read = 1'b1; s_waitrequest = 1'b1;
        step(); step();
        m0_read = 1'b0;
        step();
        chk("drop_s_read", 64'(s_read), 64'(1'b0));
        chk("drop_busy", 64'(busy), 64'(1'b0));
        s_waitrequest = 1'b0;
        m0_read = 1'b1; m1_address = 32'h0000_0500; m1_read = 1'b1;
        step();
        chk("drop_tie_m1", 64'(s_address), 64'h500);
        chk("drop_tie_m1_wait", 64'(m1_waitrequest), 64'(1'b0));
        idle_all();
        step(); step();

        // Lone requester streaming: busy toggles 1,0,1,0,1.
        m1_address = 32'h0000_0600; m1_read = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stream_busy", 64'(busy), 64'(i % 2 == 0));
        end
        idle_all();
        step();

        // Randomized traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 3000; i++) begin
            rv = $urandom;
            m0_read  = rv[0] & rv[1];
            m0_write = rv[2] & rv[3] & rv[4];
            m1_read  = rv[5] & rv[6];
            m1_write = rv[7] & rv[8] & rv[9];
            s_waitrequest = rv[10] & rv[11];
            m0_byteenable = rv[15:12];
            m1_byteenable = rv[19:16];
            m0_address = $urandom; m1_address = $urandom;
            m0_writedata = $urandom; m1_writedata = $urandom; s_readdata = $urandom;
            if (rv[31:23] == 9'd0) begin
                #2 reset = 1'b0;
                #1;
                chk("rnd_rst_busy", 64'(busy), 64'(1'b0));
                reset = 1'b1;
            end
            step();
        end
        idle_all();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
